// File: rtl/fermat_mod_mult.sv
// fermat_mod_mult: bit-serial modular multiplier, res = (a * b) mod p, with
// p = 2^m + 1 (65537 for m = 16). Operands and results are canonical values
// in [0, 2^m]. One operation in flight. After a pair is accepted, the bits of
// b are scanned MSB first (double-and-add), one bit per clock.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. valid must not depend on ready. in_a/in_b are sampled only on
// the accepting edge. out_res/out_err hold steady while out_valid is high
// and out_ready is low.
//
// Build option: MODMULT_EARLY_EXIT_EN. When defined, an in-range pair with a
// zero operand skips the serial loop and completes on the accepting edge.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   in_valid  operand pair valid
//   in_ready  block can accept operands (high only in IDLE)
//   in_a      multiplicand, unsigned, WIDTH bits
//   in_b      multiplier, unsigned, WIDTH bits
//   out_valid result valid (high only in DONE)
//   out_ready consumer accepts result
//   out_res   (a*b) mod p, in [0, p-1]
//   out_err   operand out of range; qualified by out_valid
module fermat_mod_mult #(
    parameter int WIDTH = 18,
    parameter int m     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_res,
    output logic             out_err
);

    localparam int IW = $clog2(m + 1);
    // Modulus at bus width (range check) and at m+2 bits (datapath).
    localparam logic [WIDTH-1:0] P_BUS = WIDTH'((64'd1 << m) + 64'd1);
    localparam logic [m+1:0]     P_DP  = (m + 2)'((64'd1 << m) + 64'd1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state, state_n;
    logic [m:0]    a_q, a_n;
    logic [m:0]    b_q, b_n;
    logic [m:0]    acc_q, acc_n;
    logic [IW-1:0] idx_q, idx_n;
    logic [m:0]    res_q, res_n;
    logic          err_q, err_n;
    logic [m+1:0]  t;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
            idx_q <= '0;
            res_q <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_n;
            a_q   <= a_n;
            b_q   <= b_n;
            acc_q <= acc_n;
            idx_q <= idx_n;
            res_q <= res_n;
            err_q <= err_n;
        end
    end

    always_comb begin
        state_n   = state;
        a_n       = a_q;
        b_n       = b_q;
        acc_n     = acc_q;
        idx_n     = idx_q;
        res_n     = res_q;
        err_n     = err_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        t         = '0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if ((in_a >= P_BUS) || (in_b >= P_BUS)) begin
                        state_n = DONE;
                        res_n   = '0;
                        err_n   = 1'b1;
                    end
`ifdef MODMULT_EARLY_EXIT_EN
                    else if ((in_a == '0) || (in_b == '0)) begin
                        state_n = DONE;
                        res_n   = '0;
                        err_n   = 1'b0;
                    end
`endif
                    else begin
                        a_n     = in_a[m:0];
                        b_n     = in_b[m:0];
                        acc_n   = '0;
                        idx_n   = IW'(m);
                        state_n = RUN;
                    end
                end
            end
            RUN: begin
                // acc < p, so 2*acc < 2p and acc + a < 2p: one conditional
                // subtraction per step restores the canonical range, and
                // m+2 bits hold every intermediate.
                t = {acc_q, 1'b0};
                if (t >= P_DP) t = t - P_DP;
                if (b_q[idx_q]) begin
                    t = t + {1'b0, a_q};
                    if (t >= P_DP) t = t - P_DP;
                end
                acc_n = t[m:0];
                if (idx_q == '0) begin
                    state_n = DONE;
                    res_n   = t[m:0];
                    err_n   = 1'b0;
                end else begin
                    idx_n = idx_q - 1'b1;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign out_res = {{(WIDTH-m-1){1'b0}}, res_q};
    assign out_err = err_q;

endmodule

// File: tb/tb_fermat_mod_mult.sv
module tb_fermat_mod_mult;
  localparam int W = 18;
  localparam int M = 16;
  localparam longint unsigned P = (64'd1 << M) + 64'd1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic [W-1:0] out_res;
  logic out_err;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  fermat_mod_mult #(.WIDTH(W), .m(M)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_a(in_a),
    .in_b(in_b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_res(out_res),
    .out_err(out_err)
  );

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail = 0;
  logic [W-1:0] exp_q[$];
  logic exp_err_q[$];
  int exp_lat_q[$];
  int acc_cyc_q[$];

  // 0: always ready, 1: random ready, 2: never ready
  int bp_mode = 0;

  always @(posedge clk) begin
    #1;
    case (bp_mode)
      0: out_ready = 1'b1;
      1: out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Latency is counted in clock edges after the accepting edge until
  // out_valid is seen: 0 when the result is ready on the accepting edge.
  task automatic model(input longint unsigned a, input longint unsigned b);
    logic [W-1:0] r;
    logic e;
    int lat;
    e = (a >= P) || (b >= P);
    r = e ? '0 : W'((a * b) % P);
    lat = e ? 0 : M + 1;
`ifdef MODMULT_EARLY_EXIT_EN
    if (!e && (a == 0 || b == 0)) lat = 0;
`endif
    exp_q.push_back(r);
    exp_err_q.push_back(e);
    exp_lat_q.push_back(lat);
  endtask

  // ---------------- driver ----------------
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      check("send_wait_in_ready", 0, 1);
      return;
    end
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    model(a, b);
    @(posedge clk);
    #1;
    acc_cyc_q.push_back(cyc);
    in_valid = 1'b0;
    // Scramble the buses; the DUT must have captured on the accepting edge.
    in_a = W'($urandom);
    in_b = W'($urandom);
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while (exp_q.size() > 0 && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    check("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic flush();
    exp_q.delete();
    exp_err_q.delete();
    exp_lat_q.delete();
    acc_cyc_q.delete();
  endtask

  // ---------------- monitor ----------------
  logic prev_valid = 1'b0;
  logic prev_ready = 1'b0;
  logic [W-1:0] prev_res = '0;
  logic prev_err = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (out_valid && !prev_valid) begin
        if (acc_cyc_q.size() == 0 || exp_lat_q.size() == 0) begin
          check("unexpected_out_valid", 1, 0);
        end else begin
          check("latency", cyc - acc_cyc_q.pop_front(), exp_lat_q[0]);
        end
      end
      if (out_valid && prev_valid && !prev_ready) begin
        check("hold_res", out_res, prev_res);
        check("hold_err", out_err, prev_err);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          check("out_res", out_res, exp_q.pop_front());
          check("out_err", out_err, exp_err_q.pop_front());
          void'(exp_lat_q.pop_front());
        end
      end
      prev_valid = out_valid;
      prev_ready = out_ready;
      prev_res = out_res;
      prev_err = out_err;
    end
  end

  // ---------------- stimulus ----------------
  logic [W-1:0] da[10] = '{18'd12345, 18'd65536, 18'd65536, 18'd1, 18'd65537,
                           18'd3, 18'd0, 18'd777, 18'd0, 18'd65536};
  logic [W-1:0] db[10] = '{18'd6789, 18'd65536, 18'd2, 18'd65536, 18'd5,
                           18'd131071, 18'd777, 18'd0, 18'd0, 18'd0};

  initial begin
    // reset values
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_res", out_res, 0);
    check("rst_out_err", out_err, 0);
    rst_n = 1'b1;

    // reset in the middle of RUN
    send(18'd12345, 18'd6789);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrun_rst_out_valid", out_valid, 0);
    check("midrun_rst_in_ready", in_ready, 1);
    check("midrun_rst_out_res", out_res, 0);
    flush();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("midrun_no_output", out_valid, 0);

    // directed vectors, one at a time
    for (int i = 0; i < 10; i++) begin
      send(da[i], db[i]);
      wait_drain();
    end

    // backpressure: result held for 10 cycles, in_valid ignored
    bp_mode = 2;
    send(18'd100, 18'd200);
    begin
      int guard;
      guard = 0;
      while (!out_valid && guard < 50) begin
        @(negedge clk);
        guard++;
      end
      check("bp_reach_done", out_valid, 1);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_out_res", out_res, 20000);
      in_valid = (i % 2 == 0);
      in_a = W'($urandom_range(1, 65536));
      in_b = W'($urandom_range(1, 65536));
    end
    in_valid = 1'b0;
    bp_mode = 0;
    @(negedge clk);
    @(negedge clk);
    check("bp_release_in_ready", in_ready, 1);
    check("bp_release_out_valid", out_valid, 0);
    wait_drain();

    // randomized back-to-back traffic with random backpressure
    bp_mode = 1;
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      int sel;
      sel = $urandom_range(0, 9);
      a = W'($urandom_range(0, 65536));
      b = W'($urandom_range(0, 65536));
      if (sel == 0) a = 18'd65536;
      if (sel == 1) b = 18'd0;
      if (sel == 2) a = W'($urandom_range(65537, 262143));
      if (sel == 3) b = W'($urandom_range(65537, 262143));
      send(a, b);
    end
    wait_drain();
    bp_mode = 0;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
